cam_capture_ctrl: RTL and testbench

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

---
 rtl/cam_pkg.sv | 30 +++
 rtl/cam_sync.sv | 86 ++++++++
 rtl/cam_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture path: default image geometry,
// frame-buffer address/data widths and the capture FSM state encoding.
// The frame buffer and the VGA reader import the same package so all three
// agree on geometry and widths.
// ---------------------------------------------------------------------------
package cam_pkg;

  // Default image geometry (pixels per line, lines per frame)
  localparam int CAM_IMG_W = 160;
  localparam int CAM_IMG_H = 120;

  // Frame-buffer address width and RGB444 pixel width
  localparam int CAM_AW = 15;
  localparam int CAM_DW = 12;

  // Camera byte bus width
  localparam int CAM_BYTE_W = 8;

  // Capture FSM states
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_VS_HIGH = 3'd1,
    ST_WAIT_VS_LOW  = 3'd2,
    ST_CAPTURE      = 3'd3,
    ST_DONE         = 3'd4
  } cap_state_t;

endpackage

// File: rtl/cam_sync.sv
// ---------------------------------------------------------------------------
// cam_sync
// Brings the asynchronous camera signals into the clk domain and derives the
// edge events the capture FSM works from.
//
// Every camera input (PCLK, HREF, VSYNC and the byte bus) goes through the
// same two-flop chain, so a byte arrives aligned with the PCLK sample taken at
// the same instant. A third register per timing signal holds the previous
// synchronized value for edge detection.
//
// Ports:
//   clk, rst         system clock, asynchronous active-low reset
//   pclk_in          raw camera pixel clock
//   href_in          raw camera line-valid
//   vsync_in         raw camera frame sync
//   data_in[7:0]     raw camera byte
//   pclk_rise        one-cycle pulse on synchronized PCLK 0->1
//   href             synchronized HREF level
//   href_fall        one-cycle pulse on synchronized HREF 1->0
//   vsync            synchronized VSYNC level
//   vsync_rise       one-cycle pulse on synchronized VSYNC 0->1
//   vsync_fall       one-cycle pulse on synchronized VSYNC 1->0
//   data[7:0]        synchronized camera byte
// ---------------------------------------------------------------------------
module cam_sync
  import cam_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pclk_in,
  input  logic                  href_in,
  input  logic                  vsync_in,
  input  logic [CAM_BYTE_W-1:0] data_in,
  output logic                  pclk_rise,
  output logic                  href,
  output logic                  href_fall,
  output logic                  vsync,
  output logic                  vsync_rise,
  output logic                  vsync_fall,
  output logic [CAM_BYTE_W-1:0] data
);

  logic                  pclk_m,  pclk_s,  pclk_p;
  logic                  href_m,  href_s,  href_p;
  logic                  vsync_m, vsync_s, vsync_p;
  logic [CAM_BYTE_W-1:0] data_m,  data_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_m  <= 1'b0;
      pclk_s  <= 1'b0;
      pclk_p  <= 1'b0;
      href_m  <= 1'b0;
      href_s  <= 1'b0;
      href_p  <= 1'b0;
      vsync_m <= 1'b0;
      vsync_s <= 1'b0;
      vsync_p <= 1'b0;
      data_m  <= '0;
      data_s  <= '0;
    end else begin
      // Stage 1 / stage 2 of the synchronizers (identical depth on all inputs)
      pclk_m  <= pclk_in;
      pclk_s  <= pclk_m;
      href_m  <= href_in;
      href_s  <= href_m;
      vsync_m <= vsync_in;
      vsync_s <= vsync_m;
      data_m  <= data_in;
      data_s  <= data_m;
      // Previous synchronized values for edge detection
      pclk_p  <= pclk_s;
      href_p  <= href_s;
      vsync_p <= vsync_s;
    end
  end

  assign pclk_rise  =  pclk_s  & ~pclk_p;
  assign href       =  href_s;
  assign href_fall  = ~href_s  &  href_p;
  assign vsync      =  vsync_s;
  assign vsync_rise =  vsync_s & ~vsync_p;
  assign vsync_fall = ~vsync_s &  vsync_p;
  assign data       =  data_s;

endmodule

// File: rtl/cam_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cam_capture_ctrl
// Captures one (or, with cont=1, successive) RGB444 frames from an OV7670
// style camera into a dual-port frame buffer.
//
// The camera sends two bytes per pixel: the first carries R in bits [3:0],
// the second carries G in [7:4] and B in [3:0]. Each completed pixel becomes
// one write strobe, one cycle after the PCLK event of the second byte, with
// address and data valid alongside it.
//
// Handshake: DP_RAM_regW is a one-cycle write strobe; DP_RAM_addr_in and
// DP_RAM_data_in are valid whenever DP_RAM_regW=1. The RAM is always ready,
// so there is no back-pressure.
//
// Ports:
//   clk, rst                      system clock, asynchronous active-low reset
//   start                         one-cycle capture request (honoured in IDLE)
//   cont                          1 = keep capturing frame after frame
//   CAM_PCLK/CAM_HREF/CAM_VSYNC   raw camera timing
//   CAM_px_data[7:0]              raw camera byte
//   DP_RAM_addr_in[AW-1:0]        write address
//   DP_RAM_data_in[DW-1:0]        write data {R,G,B}
//   DP_RAM_regW                   write strobe
//   busy                          FSM not in IDLE
//   frame_done                    one-cycle pulse when a frame ends
//   line_err                      sticky: some line had the wrong pixel count
// ---------------------------------------------------------------------------
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int IMG_W = CAM_IMG_W,
  parameter int IMG_H = CAM_IMG_H,
  parameter int AW    = CAM_AW,
  parameter int DW    = CAM_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  CAM_PCLK,
  input  logic                  CAM_HREF,
  input  logic                  CAM_VSYNC,
  input  logic [CAM_BYTE_W-1:0] CAM_px_data,
  output logic [AW-1:0]         DP_RAM_addr_in,
  output logic [DW-1:0]         DP_RAM_data_in,
  output logic                  DP_RAM_regW,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  line_err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  // One spare bit so an over-long line cannot alias back to IMG_W
  localparam int            LCW       = $clog2(IMG_W + 1) + 1;
  localparam logic [LCW-1:0] LINE_PIX = LCW'(IMG_W);

  // Synchronized camera view
  logic                  pclk_rise;
  logic                  href_s;
  logic                  href_fall;
  logic                  vsync_s;
  logic                  vsync_rise;
  logic                  vsync_fall;
  logic [CAM_BYTE_W-1:0] byte_s;

  cam_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .pclk_in    (CAM_PCLK),
    .href_in    (CAM_HREF),
    .vsync_in   (CAM_VSYNC),
    .data_in    (CAM_px_data),
    .pclk_rise  (pclk_rise),
    .href       (href_s),
    .href_fall  (href_fall),
    .vsync      (vsync_s),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .data       (byte_s)
  );

  // FSM state and datapath registers
  cap_state_t     state;
  logic           phase;     // 0 = expecting R byte, 1 = expecting G/B byte
  logic [3:0]     r_nib;
  logic [LCW-1:0] line_cnt;  // pixels completed in the current line
  logic           full;      // last frame-buffer location has been written

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      phase          <= 1'b0;
      r_nib          <= '0;
      line_cnt       <= '0;
      full           <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
    end else begin
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;

      // Address advances once the write strobe has been presented; it sticks
      // at the last location instead of wrapping onto pixel 0.
      if (DP_RAM_regW) begin
        if (DP_RAM_addr_in == LAST_ADDR) full <= 1'b1;
        else                             DP_RAM_addr_in <= DP_RAM_addr_in + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT_VS_HIGH;
            line_err <= 1'b0;
          end
        end

        // Wait for the current frame (if any) to end so capture always
        // starts on a clean frame boundary.
        ST_WAIT_VS_HIGH: begin
          if (vsync_s) state <= ST_WAIT_VS_LOW;
        end

        ST_WAIT_VS_LOW: begin
          if (vsync_fall) begin
            state          <= ST_CAPTURE;
            DP_RAM_addr_in <= '0;
            full           <= 1'b0;
            phase          <= 1'b0;
            line_cnt       <= '0;
          end
        end

        ST_CAPTURE: begin
          if (vsync_rise) begin
            // A strobe already on the bus this cycle still completes: the
            // address update above runs regardless of the state change.
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end else if (href_fall) begin
            // Line end: drop any half pixel and check the line length.
            phase    <= 1'b0;
            line_cnt <= '0;
            if (line_cnt != LINE_PIX) line_err <= 1'b1;
          end else if (pclk_rise && href_s) begin
            if (!phase) begin
              r_nib <= byte_s[3:0];
              phase <= 1'b1;
            end else begin
              phase          <= 1'b0;
              DP_RAM_data_in <= DW'({r_nib, byte_s});
              DP_RAM_regW    <= ~full;
              if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= cont ? ST_WAIT_VS_LOW : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_capture_ctrl
// Bench for cam_capture_ctrl with a reduced 16x8 image so whole frames stay
// short. A camera driver emits bytes; for every completed pixel that should
// land in the frame buffer the expected {addr,data} is queued, and a monitor
// pops and compares on each write strobe.
// ---------------------------------------------------------------------------
module tb_cam_capture_ctrl;

  localparam int IMG_W = 16;
  localparam int IMG_H = 8;
  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          cont;
  logic          cam_pclk;
  logic          cam_href;
  logic          cam_vsync;
  logic [7:0]    cam_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic          busy;
  logic          frame_done;
  logic          line_err;

  cam_capture_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cont           (cont),
    .CAM_PCLK       (cam_pclk),
    .CAM_HREF       (cam_href),
    .CAM_VSYNC      (cam_vsync),
    .CAM_px_data    (cam_data),
    .DP_RAM_addr_in (ram_addr),
    .DP_RAM_data_in (ram_data),
    .DP_RAM_regW    (ram_we),
    .busy           (busy),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int fd_cnt   = 0;
  int spurious = 0;
  logic [AW-1:0] last_wr_addr = '0;
  int m_n = 0;  // pixels the model has seen in the current captured frame

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (frame_done) fd_cnt++;
      if (ram_we) begin
        wr_cnt++;
        last_wr_addr = ram_addr;
        if (exp_q.size() == 0) spurious++;
        else begin
          mon_exp = exp_q.pop_front();
          check("wr", 32'({ram_addr, ram_data}), 32'(mon_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    wait_clk(24);
    cam_vsync = 1'b0;
    wait_clk(24);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_pclk = 1'b0;
    cam_data = b;
    wait_clk(4);
    cam_pclk = 1'b1;
    wait_clk(4);
  endtask

  // mode 0: every byte = bval; mode 1: random bytes
  task automatic send_line(input int nbytes, input int mode, input logic [7:0] bval,
                           input bit expect_wr);
    logic [7:0] b;
    logic [3:0] r;
    r = '0;
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      b = (mode == 1) ? 8'($urandom_range(0, 255)) : bval;
      if (i % 2 == 0) r = b[3:0];
      else begin
        if (expect_wr && m_n < TOTAL) exp_q.push_back({AW'(m_n), r, b});
        m_n++;
      end
      send_byte(b);
    end
    cam_pclk = 1'b0;
    wait_clk(4);
    cam_href = 1'b0;
    wait_clk(24);
  endtask

  task automatic send_lines(input int nlines, input int mode, input logic [7:0] bval,
                            input bit expect_wr, input bit fresh);
    if (fresh) m_n = 0;
    for (int l = 0; l < nlines; l++) send_line(2 * IMG_W, mode, bval, expect_wr);
  endtask

  // ---------------- test sequence ----------------
  int w0, f0;

  initial begin
    rst = 1'b0; start = 1'b0; cont = 1'b0;
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0; cam_data = '0;
    wait_clk(5);
    check("rst_we",    32'(ram_we),     0);
    check("rst_busy",  32'(busy),       0);
    check("rst_fd",    32'(frame_done), 0);
    check("rst_lerr",  32'(line_err),   0);
    check("rst_addr",  32'(ram_addr),   0);
    check("rst_data",  32'(ram_data),   0);
    rst = 1'b1;
    wait_clk(5);

    // Single frame of 0x0F bytes -> every pixel 12'hF0F
    w0 = wr_cnt; f0 = fd_cnt;
    pulse_start();
    wait_clk(2);
    check("t1_busy", 32'(busy), 1);
    vsync_pulse();
    send_lines(IMG_H, 0, 8'h0F, 1'b1, 1'b1);
    vsync_pulse();
    check("t1_writes", 32'(wr_cnt - w0), 32'(TOTAL));
    check("t1_fd",     32'(fd_cnt - f0), 1);
    check("t1_lerr",   32'(line_err),    0);
    check("t1_idle",   32'(busy),        0);
    check("t1_addr",   32'(ram_addr),    32'(LAST));
    check("t1_drain",  32'(exp_q.size()), 0);

    // Continuous: random frame, then a 0xF0 frame with no new start
    w0 = wr_cnt; f0 = fd_cnt;
    cont = 1'b1;
    pulse_start();
    vsync_pulse();
    send_lines(IMG_H, 1, 8'h00, 1'b1, 1'b1);
    vsync_pulse();
    check("t2_busy_between", 32'(busy), 1);
    send_lines(IMG_H, 0, 8'hF0, 1'b1, 1'b1);
    cont = 1'b0;
    vsync_pulse();
    check("t2_writes", 32'(wr_cnt - w0), 32'(2 * TOTAL));
    check("t2_fd",     32'(fd_cnt - f0), 2);
    check("t2_idle",   32'(busy),        0);
    check("t2_drain",  32'(exp_q.size()), 0);

    // Short line with a dangling R byte
    w0 = wr_cnt; f0 = fd_cnt;
    pulse_start();
    vsync_pulse();
    send_lines(3, 1, 8'h00, 1'b1, 1'b1);
    check("t3_lerr_before", 32'(line_err), 0);
    send_line(2 * IMG_W - 1, 1, 8'h00, 1'b1);
    check("t3_lerr_set", 32'(line_err), 1);
    send_lines(IMG_H - 4, 1, 8'h00, 1'b1, 1'b0);
    vsync_pulse();
    check("t3_writes",    32'(wr_cnt - w0), 32'(TOTAL - 1));
    check("t3_lerr_hold", 32'(line_err),    1);
    check("t3_fd",        32'(fd_cnt - f0), 1);
    check("t3_drain",     32'(exp_q.size()), 0);

    // Reset in the middle of a frame
    w0 = wr_cnt; f0 = fd_cnt;
    pulse_start();
    wait_clk(2);
    check("t4_lerr_clr", 32'(line_err), 0);
    vsync_pulse();
    send_lines(3, 1, 8'h00, 1'b1, 1'b1);
    check("t4_addr_pre", 32'(ram_addr), 32'(3 * IMG_W));
    check("t4_drain",    32'(exp_q.size()), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t4_rst_we",   32'(ram_we),   0);
      check("t4_rst_busy", 32'(busy),     0);
      check("t4_rst_addr", 32'(ram_addr), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    check("t4_idle", 32'(busy), 0);
    send_lines(IMG_H - 3, 1, 8'h00, 1'b0, 1'b0);
    vsync_pulse();
    check("t4_writes", 32'(wr_cnt - w0), 32'(3 * IMG_W));
    check("t4_fd",     32'(fd_cnt - f0), 0);

    // Start in the middle of a frame: capture waits for the next frame
    vsync_pulse();
    send_lines(3, 1, 8'h00, 1'b0, 1'b1);
    w0 = wr_cnt; f0 = fd_cnt;
    pulse_start();
    wait_clk(2);
    check("t5_busy", 32'(busy), 1);
    send_lines(IMG_H - 3, 1, 8'h00, 1'b0, 1'b0);
    check("t5_nowr_yet", 32'(wr_cnt - w0), 0);
    vsync_pulse();
    send_lines(IMG_H, 1, 8'h00, 1'b1, 1'b1);
    vsync_pulse();
    check("t5_writes", 32'(wr_cnt - w0), 32'(TOTAL));
    check("t5_fd",     32'(fd_cnt - f0), 1);
    check("t5_drain",  32'(exp_q.size()), 0);

    // Too many lines: address saturates at the last location
    w0 = wr_cnt; f0 = fd_cnt;
    pulse_start();
    vsync_pulse();
    send_lines(IMG_H + 2, 1, 8'h00, 1'b1, 1'b1);
    vsync_pulse();
    check("t6_writes",  32'(wr_cnt - w0),  32'(TOTAL));
    check("t6_last_wr", 32'(last_wr_addr), 32'(LAST));
    check("t6_addr",    32'(ram_addr),     32'(LAST));
    check("t6_lerr",    32'(line_err),     0);
    check("t6_fd",      32'(fd_cnt - f0),  1);

    check("no_spurious_wr", 32'(spurious),     0);
    check("final_drain",    32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
